// File: rtl/tcm_pmem_guard_pkg.sv
// Shared constants, entry encodings and the address classifier for the TCM pmem guard.
// ROM sits at offset 0 with RAM directly above it; everything past that span is rejected.
package tcm_pmem_guard_pkg;

  localparam int unsigned TCM_ROM_SIZE_DEF = 16384;
  localparam int unsigned TCM_RAM_SIZE_DEF = 49152;
  localparam int unsigned OUTSTANDING_DEF  = 4;

  localparam int unsigned OFF_W         = 16;
  localparam int unsigned BLOCKED_CNT_W = 16;
  localparam logic [BLOCKED_CNT_W-1:0] BLOCKED_CNT_MAX = '1;

  typedef enum logic {
    ENTRY_FWD   = 1'b0,
    ENTRY_LOCAL = 1'b1
  } entry_e;

  // The offset is widened before comparing so that a span of exactly 64 KiB never matches.
  function automatic logic is_blocked(input logic [OFF_W-1:0] off,
                                      input logic             is_wr,
                                      input int unsigned      rom_size,
                                      input int unsigned      ram_size);
    int unsigned off_u;
    off_u = 32'(off);
    return (is_wr && (off_u < rom_size)) || (off_u >= (rom_size + ram_size));
  endfunction

endpackage

// File: rtl/tcm_pmem_guard_fifo.sv
// In-order tracking FIFO: one bit per outstanding request (forwarded or local).
// local_pending_o reports whether any occupied slot holds a local entry.
module tcm_pmem_guard_fifo
  import tcm_pmem_guard_pkg::*;
#(
  parameter int unsigned DEPTH = OUTSTANDING_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic pop_i,
  input  logic data_in_i,
  output logic head_o,
  output logic empty_o,
  output logic full_o,
  output logic local_pending_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_CNT);
  assign head_o  = mem_q[rd_ptr_q];
  assign local_pending_o = |(mem_q & valid_q);

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    valid_d  = valid_q;
    if (push_ok) begin
      mem_d[wr_ptr_q]   = data_in_i;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/tcm_pmem_guard.sv
// Guard between the AXI-to-pmem converter and the TCM pmem port: forwards legal requests,
// answers illegal ones locally with an error, and keeps every response in request order.
module tcm_pmem_guard
  import tcm_pmem_guard_pkg::*;
#(
  parameter int unsigned TCM_ROM_SIZE = TCM_ROM_SIZE_DEF,
  parameter int unsigned TCM_RAM_SIZE = TCM_RAM_SIZE_DEF,
  parameter int unsigned OUTSTANDING  = OUTSTANDING_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [3:0]               up_wr_i,
  input  logic                     up_rd_i,
  input  logic [7:0]               up_len_i,
  input  logic [31:0]              up_addr_i,
  input  logic [31:0]              up_write_data_i,
  output logic                     up_accept_o,
  output logic                     up_ack_o,
  output logic                     up_error_o,
  output logic [31:0]              up_read_data_o,
  output logic [3:0]               dn_wr_o,
  output logic                     dn_rd_o,
  output logic [7:0]               dn_len_o,
  output logic [31:0]              dn_addr_o,
  output logic [31:0]              dn_write_data_o,
  input  logic                     dn_accept_i,
  input  logic                     dn_ack_i,
  input  logic                     dn_error_i,
  input  logic [31:0]              dn_read_data_i,
  output logic [BLOCKED_CNT_W-1:0] blocked_count_o,
  output logic                     violation_o
);

  logic req, blocked, fwd_ok, push;
  logic fifo_head, fifo_empty, fifo_full, local_pending;
  logic fwd_ack, local_pop, pop;
  logic local_ack_q, local_ack_d;
  logic violation_q, violation_d;
  logic [BLOCKED_CNT_W-1:0] blocked_count_q, blocked_count_d;

  assign req     = up_rd_i | (|up_wr_i);
  assign blocked = is_blocked(up_addr_i[OFF_W-1:0], |up_wr_i, TCM_ROM_SIZE, TCM_RAM_SIZE);

  // Forwarding waits behind any local entry so TCM acks always belong to the FIFO head.
  assign fwd_ok  = ~blocked & ~fifo_full & ~local_pending;

  assign dn_rd_o         = up_rd_i & fwd_ok;
  assign dn_wr_o         = up_wr_i & {4{fwd_ok}};
  assign dn_len_o        = up_len_i;
  assign dn_addr_o       = up_addr_i;
  assign dn_write_data_o = up_write_data_i;

  assign up_accept_o = req & ~rst_i & ~fifo_full & (blocked | (~local_pending & dn_accept_i));
  assign push        = up_accept_o;

  assign fwd_ack   = dn_ack_i & ~fifo_empty & (fifo_head == ENTRY_FWD);
  assign local_pop = ~fifo_empty & (fifo_head == ENTRY_LOCAL) & ~local_ack_q;
  assign pop       = fwd_ack | local_pop;

  tcm_pmem_guard_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_fifo (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .push_i          (push),
    .pop_i           (pop),
    .data_in_i       (blocked ? ENTRY_LOCAL : ENTRY_FWD),
    .head_o          (fifo_head),
    .empty_o         (fifo_empty),
    .full_o          (fifo_full),
    .local_pending_o (local_pending)
  );

  assign up_ack_o       = fwd_ack | local_ack_q;
  assign up_error_o     = local_ack_q | (fwd_ack & dn_error_i);
  assign up_read_data_o = fwd_ack ? dn_read_data_i : '0;

  always_comb begin
    local_ack_d     = local_pop;
    violation_d     = violation_q | (dn_ack_i & ~fwd_ack);
    blocked_count_d = blocked_count_q;
    if (push && blocked && (blocked_count_q != BLOCKED_CNT_MAX)) begin
      blocked_count_d = blocked_count_q + BLOCKED_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      local_ack_q     <= 1'b0;
      violation_q     <= 1'b0;
      blocked_count_q <= '0;
    end else begin
      local_ack_q     <= local_ack_d;
      violation_q     <= violation_d;
      blocked_count_q <= blocked_count_d;
    end
  end

  assign blocked_count_o = blocked_count_q;
  assign violation_o     = violation_q;

endmodule

// File: tb/tb_tcm_pmem_guard.sv
// Directed bench for tcm_pmem_guard; a second instance uses a 32 KiB RAM to reach the span limit.
`timescale 1ns/1ps
module tb_tcm_pmem_guard;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  up_wr;
  logic        up_rd;
  logic [7:0]  up_len;
  logic [31:0] up_addr, up_wdata;
  logic        up_accept, up_ack, up_error;
  logic [31:0] up_rdata;
  logic [3:0]  dn_wr;
  logic        dn_rd;
  logic [7:0]  dn_len;
  logic [31:0] dn_addr, dn_wdata;
  logic        dn_accept, dn_ack, dn_error;
  logic [31:0] dn_rdata;
  logic [15:0] blk_cnt;
  logic        violation;

  logic        u2_rd;
  logic [31:0] u2_addr;
  logic        u2_accept, u2_ack, u2_error, u2_violation;
  logic [31:0] u2_rdata, u2_dn_addr, u2_dn_wdata;
  logic [3:0]  u2_dn_wr;
  logic        u2_dn_rd, u2_dn_accept;
  logic [7:0]  u2_dn_len;
  logic [15:0] u2_blk_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  tcm_pmem_guard u_dut (
    .clk_i(clk), .rst_i(rst),
    .up_wr_i(up_wr), .up_rd_i(up_rd), .up_len_i(up_len), .up_addr_i(up_addr),
    .up_write_data_i(up_wdata), .up_accept_o(up_accept), .up_ack_o(up_ack),
    .up_error_o(up_error), .up_read_data_o(up_rdata),
    .dn_wr_o(dn_wr), .dn_rd_o(dn_rd), .dn_len_o(dn_len), .dn_addr_o(dn_addr),
    .dn_write_data_o(dn_wdata), .dn_accept_i(dn_accept), .dn_ack_i(dn_ack),
    .dn_error_i(dn_error), .dn_read_data_i(dn_rdata),
    .blocked_count_o(blk_cnt), .violation_o(violation)
  );

  tcm_pmem_guard #(.TCM_RAM_SIZE(32768)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .up_wr_i(4'h0), .up_rd_i(u2_rd), .up_len_i(8'h00), .up_addr_i(u2_addr),
    .up_write_data_i(32'h0), .up_accept_o(u2_accept), .up_ack_o(u2_ack),
    .up_error_o(u2_error), .up_read_data_o(u2_rdata),
    .dn_wr_o(u2_dn_wr), .dn_rd_o(u2_dn_rd), .dn_len_o(u2_dn_len), .dn_addr_o(u2_dn_addr),
    .dn_write_data_o(u2_dn_wdata), .dn_accept_i(u2_dn_accept), .dn_ack_i(1'b0),
    .dn_error_i(1'b0), .dn_read_data_i(32'h0),
    .blocked_count_o(u2_blk_cnt), .violation_o(u2_violation)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a forwarded read that the TCM accepts in the same cycle.
  task automatic fwd_read(input string tag, input logic [31:0] addr);
    up_rd = 1'b1; up_addr = addr;
    #1;
    $display("txn %s: read addr=%h dn_rd=%b accept=%b", tag, addr, dn_rd, up_accept);
    check({tag, "_dn_rd"}, 32'(dn_rd), 32'd1);
    check({tag, "_accept"}, 32'(up_accept), 32'd1);
    check({tag, "_dn_addr"}, dn_addr, addr);
    tick();
    up_rd = 1'b0;
  endtask

  task automatic tcm_ack(input string tag, input logic [31:0] data, input logic err);
    dn_ack = 1'b1; dn_rdata = data; dn_error = err;
    #1;
    $display("txn %s: tcm ack data=%h err=%b -> up_ack=%b", tag, data, err, up_ack);
    check({tag, "_ack"}, 32'(up_ack), 32'd1);
    check({tag, "_err"}, 32'(up_error), 32'(err));
    check({tag, "_data"}, up_rdata, data);
    tick();
    dn_ack = 1'b0; dn_rdata = '0; dn_error = 1'b0;
  endtask

  task automatic blocked_write(input string tag, input logic [31:0] addr);
    bit got = 0;
    up_wr = 4'hF; up_addr = addr;
    for (int i = 0; i < 8 && !got; i++) begin
      #1;
      if (up_accept) got = 1;
      @(posedge clk);
      #1;
    end
    up_wr = 4'h0;
    $display("txn %s: blocked write addr=%h accepted=%0d", tag, addr, got);
    check({tag, "_accepted"}, 32'(got), 32'd1);
  endtask

  task automatic wait_ack(output bit got, output logic err, output logic [31:0] data);
    got = 0; err = 1'b0; data = '0;
    for (int i = 0; i < 6 && !got; i++) begin
      #1;
      if (up_ack) begin
        got = 1; err = up_error; data = up_rdata;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit          got;
    logic        err;
    logic [31:0] data;

    rst = 1'b1; up_wr = '0; up_rd = 1'b0; up_len = 8'h03; up_addr = 32'h1234;
    up_wdata = 32'h5555AAAA; dn_accept = 1'b0; dn_ack = 1'b0; dn_error = 1'b0;
    dn_rdata = '0; u2_rd = 1'b0; u2_addr = '0; u2_dn_accept = 1'b0;
    repeat (3) tick();

    check("rst_ack", 32'(up_ack), 32'd0);
    check("rst_err", 32'(up_error), 32'd0);
    check("rst_rdata", up_rdata, 32'd0);
    check("rst_accept", 32'(up_accept), 32'd0);
    check("rst_cnt", 32'(blk_cnt), 32'd0);
    check("rst_viol", 32'(violation), 32'd0);
    check("rst_dn_rd", 32'(dn_rd), 32'd0);
    check("rst_dn_wr", 32'(dn_wr), 32'd0);
    check("pass_addr", dn_addr, 32'h1234);
    check("pass_len", 32'(dn_len), 32'h03);
    check("pass_wdata", dn_wdata, 32'h5555AAAA);
    rst = 1'b0;
    tick();

    // Plain forwarded read at the first RAM byte.
    dn_accept = 1'b1;
    fwd_read("rd_4000", 32'h0000_4000);
    tcm_ack("rd_4000", 32'hDEADBEEF, 1'b0);
    check("rd_4000_cnt", 32'(blk_cnt), 32'd0);

    // ROM write is answered locally with an error.
    up_wr = 4'hF; up_addr = 32'h0000_0010;
    #1;
    check("wr_rom_dn_wr", 32'(dn_wr), 32'd0);
    check("wr_rom_accept", 32'(up_accept), 32'd1);
    tick();
    up_wr = 4'h0;
    wait_ack(got, err, data);
    $display("txn wr_rom: local ack got=%0d err=%b data=%h", got, err, data);
    check("wr_rom_ack", 32'(got), 32'd1);
    check("wr_rom_err", 32'(err), 32'd1);
    check("wr_rom_data", data, 32'd0);
    check("wr_rom_cnt", 32'(blk_cnt), 32'd1);

    fwd_read("rd_rom", 32'h0000_0010);
    tcm_ack("rd_rom", 32'hCAFEF00D, 1'b0);
    fwd_read("rd_fffc", 32'h0000_FFFC);
    tcm_ack("rd_fffc", 32'h0BADC0DE, 1'b1);
    fwd_read("rd_10000", 32'h0001_0000);
    tcm_ack("rd_10000", 32'h13572468, 1'b0);

    // Smaller RAM: the first byte past the span is rejected, the last legal word forwarded.
    u2_rd = 1'b1; u2_addr = 32'h0000_C000;
    #1;
    check("span_dn_rd", 32'(u2_dn_rd), 32'd0);
    check("span_accept", 32'(u2_accept), 32'd1);
    tick();
    u2_rd = 1'b0;
    got = 0; err = 1'b0; data = 32'hFFFFFFFF;
    for (int i = 0; i < 6 && !got; i++) begin
      #1;
      if (u2_ack) begin
        got = 1; err = u2_error; data = u2_rdata;
      end
      tick();
    end
    $display("txn span: read 0000c000 ack=%0d err=%b", got, err);
    check("span_ack", 32'(got), 32'd1);
    check("span_err", 32'(err), 32'd1);
    check("span_data", data, 32'd0);
    check("span_cnt", 32'(u2_blk_cnt), 32'd1);
    u2_rd = 1'b1; u2_addr = 32'h0000_BFFC; u2_dn_accept = 1'b1;
    #1;
    check("span_last_dn_rd", 32'(u2_dn_rd), 32'd1);
    u2_rd = 1'b0; u2_dn_accept = 1'b0;
    tick();

    // Ordering: forwarded, blocked, forwarded -> ok, error, ok.
    up_rd = 1'b1; up_addr = 32'h0000_5000;
    #1;
    check("ord_r1_accept", 32'(up_accept), 32'd1);
    tick();
    up_rd = 1'b0; up_wr = 4'h3; up_addr = 32'h0000_0020;
    #1;
    check("ord_w_accept", 32'(up_accept), 32'd1);
    check("ord_w_dn_wr", 32'(dn_wr), 32'd0);
    tick();
    up_wr = 4'h0; up_rd = 1'b1; up_addr = 32'h0000_5004;
    #1;
    check("ord_r2_stall", 32'(up_accept), 32'd0);
    check("ord_r2_dn_rd", 32'(dn_rd), 32'd0);
    dn_ack = 1'b1; dn_rdata = 32'h11111111;
    #1;
    check("ord_ack1", 32'(up_ack), 32'd1);
    check("ord_ack1_err", 32'(up_error), 32'd0);
    check("ord_ack1_data", up_rdata, 32'h11111111);
    tick();
    dn_ack = 1'b0; dn_rdata = '0;
    #1;
    check("ord_pop_ack", 32'(up_ack), 32'd0);
    check("ord_pop_stall", 32'(up_accept), 32'd0);
    tick();
    #1;
    check("ord_ack2", 32'(up_ack), 32'd1);
    check("ord_ack2_err", 32'(up_error), 32'd1);
    check("ord_ack2_data", up_rdata, 32'd0);
    check("ord_r2_accept", 32'(up_accept), 32'd1);
    check("ord_r2_fwd", 32'(dn_rd), 32'd1);
    tick();
    up_rd = 1'b0;
    tcm_ack("ord_ack3", 32'h22222222, 1'b0);
    check("ord_cnt", 32'(blk_cnt), 32'd2);

    // Fill the tracking FIFO with never-acked reads.
    up_rd = 1'b1; up_addr = 32'h0000_8000;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("full_acc%0d", k), 32'(up_accept), 32'd1);
      tick();
    end
    #1;
    check("full_accept", 32'(up_accept), 32'd0);
    check("full_dn_rd", 32'(dn_rd), 32'd0);
    dn_ack = 1'b1; dn_rdata = 32'h000000A0;
    #1;
    check("full_ack", 32'(up_ack), 32'd1);
    check("full_ack_data", up_rdata, 32'h000000A0);
    tick();
    dn_ack = 1'b0;
    #1;
    check("full_reaccept", 32'(up_accept), 32'd1);
    tick();
    up_rd = 1'b0;
    tcm_ack("drain1", 32'h000000A1, 1'b0);
    tcm_ack("drain2", 32'h000000A2, 1'b0);
    tcm_ack("drain3", 32'h000000A3, 1'b0);
    tcm_ack("drain4", 32'h000000A4, 1'b0);

    // Stray TCM ack with nothing outstanding.
    check("viol_before", 32'(violation), 32'd0);
    dn_ack = 1'b1; dn_rdata = 32'h00000099;
    #1;
    check("viol_no_ack", 32'(up_ack), 32'd0);
    tick();
    dn_ack = 1'b0; dn_rdata = '0;
    check("viol_set", 32'(violation), 32'd1);
    repeat (3) tick();
    check("viol_sticky", 32'(violation), 32'd1);

    // Preload the counter near saturation to keep the run short.
    force u_dut.blocked_count_q = 16'hFFFD;
    #1;
    release u_dut.blocked_count_q;
    blocked_write("sat1", 32'h0000_0100);
    check("sat_fffe", 32'(blk_cnt), 32'h0000FFFE);
    blocked_write("sat2", 32'h0000_0104);
    check("sat_ffff", 32'(blk_cnt), 32'h0000FFFF);
    up_wr = 4'hF; up_addr = 32'h0000_0108;
    repeat (10) tick();
    check("sat_hold", 32'(blk_cnt), 32'h0000FFFF);

    // Reset in the middle of the blocked burst.
    rst = 1'b1;
    #1;
    check("mid_rst_accept", 32'(up_accept), 32'd0);
    check("mid_rst_ack", 32'(up_ack), 32'd0);
    check("mid_rst_err", 32'(up_error), 32'd0);
    check("mid_rst_rdata", up_rdata, 32'd0);
    check("mid_rst_cnt", 32'(blk_cnt), 32'd0);
    check("mid_rst_viol", 32'(violation), 32'd0);
    up_wr = 4'h0;
    tick();
    rst = 1'b0;
    tick();
    fwd_read("post_rst", 32'h0000_4000);
    tcm_ack("post_rst", 32'h87654321, 1'b0);
    check("post_rst_viol", 32'(violation), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
